arm_dmem_ws: RTL

- Parametrised data memory for the ARM core family; successor to the fixed 64-word, zero-latency data memory.
- Adds configurable width, depth and access latency, plus per-byte write enables for STRB and sub-word stores.
- Uses a req/ready/done handshake so multicycle and pipelined cores can stall on it.
- Flags out-of-range accesses instead of silently aliasing them.

---
 rtl/arm_dmem_ws_if.sv | 24 ++
 rtl/arm_dmem_ws.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/arm_dmem_ws_if.sv
// rtl/arm_dmem_ws_if.sv - req/ready/done bus bundle for the parametrised data memory
interface arm_dmem_ws_if #(
    parameter int WIDTH = 32
);
    logic               req;
    logic               we;
    logic [WIDTH/8-1:0] be;
    logic [31:0]        a;
    logic [WIDTH-1:0]   wd;
    logic               ready;
    logic               done;
    logic [WIDTH-1:0]   rd;
    logic               err;

    modport master (
        output req, we, be, a, wd,
        input  ready, done, rd, err
    );

    modport slave (
        input  req, we, be, a, wd,
        output ready, done, rd, err
    );
endinterface

// File: rtl/arm_dmem_ws.sv
// rtl/arm_dmem_ws.sv - data memory with byte enables, configurable wait states and range flag
module arm_dmem_ws #(
    parameter int    WIDTH     = 32,
    parameter int    DEPTH     = 64,
    parameter int    LATENCY   = 0,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          reset,
    arm_dmem_ws_if.slave  bus
);
    localparam int NB = WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             perform;
    logic             accept;

    // Access captured at accept, replayed when the wait count expires.
    logic             l_we;
    logic [NB-1:0]    l_be;
    logic [IW-1:0]    l_idx;
    logic [WIDTH-1:0] l_wd;
    logic             l_ok;

    // The access actually committed this edge: live inputs when there are no
    // wait states, otherwise the captured copy.
    logic             p_we;
    logic [NB-1:0]    p_be;
    logic [IW-1:0]    p_idx;
    logic [WIDTH-1:0] p_wd;
    logic             p_ok;

    logic [31:0]      word_addr;
    logic             in_range;
    logic [IW-1:0]    in_idx;

    logic             done_q, err_q;
    logic [WIDTH-1:0] rd_q;

    logic [WIDTH-1:0] ram [DEPTH];

    assign word_addr = bus.a >> OB;
    assign in_range  = word_addr < 32'(DEPTH);
    assign in_idx    = word_addr[IW-1:0];
    assign bus.ready = (state == IDLE);
    assign accept    = bus.req && bus.ready;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rd    = rd_q;

    // Select the access source for the commit edge.
    always_comb begin
        p_we  = l_we;
        p_be  = l_be;
        p_idx = l_idx;
        p_wd  = l_wd;
        p_ok  = l_ok;
        if (LATENCY == 0) begin
            p_we  = bus.we;
            p_be  = bus.be;
            p_idx = in_idx;
            p_wd  = bus.wd;
            p_ok  = in_range;
        end
    end

    // Next-state logic: commit on accept with no wait states, else count down in WAIT.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        perform  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        perform = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    perform  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and wait counter; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Capture the request on accept so req may drop during WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_we  <= 1'b0;
            l_be  <= '0;
            l_idx <= '0;
            l_wd  <= '0;
            l_ok  <= 1'b0;
        end else if (accept) begin
            l_we  <= bus.we;
            l_be  <= bus.be;
            l_idx <= in_idx;
            l_wd  <= bus.wd;
            l_ok  <= in_range;
        end
    end

    // Completion pulse and read data; rd holds across writes and idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            rd_q   <= '0;
        end else begin
            done_q <= perform;
            err_q  <= perform && !p_ok;
            if (perform && !p_we) begin
                rd_q <= p_ok ? ram[p_idx] : '0;
            end
        end
    end

    // Byte-lane write; gated by reset so an aborted access never commits.
    always_ff @(posedge clk) begin
        if (perform && !reset && p_we && p_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (p_be[i]) ram[p_idx][8*i +: 8] <= p_wd[8*i +: 8];
            end
        end
    end
endmodule
